// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM state codes,
// frame geometry and the bit-time derivation helpers.
package fifo_uart_tx_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LATCH = 3'd2;
    localparam logic [2:0] ST_START = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_STOP  = 3'd5;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int UART_FRAME_BITS    = DEFAULT_DATA_WIDTH + 2;

    // Smallest n with 2**n >= value (0 for value <= 1).
    function automatic int log2_ceil(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Cycles per serial bit, truncated like the reference clock divider.
    function automatic int calc_clks_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    // Start bit + data bits + stop bit.
    function automatic int frame_bits(input int data_width);
        return data_width + 2;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read side of the byte FIFO. The transmitter is the master (the reader);
// the FIFO is the slave. Read data is valid the cycle after fifo_rd_en.
interface fifo_uart_tx_if #(
    parameter int data_width = 8
);
    logic                  fifo_empty;
    logic [data_width-1:0] fifo_dout;
    logic                  fifo_rd_en;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        input  fifo_rd_en
    );
endinterface

// File: rtl/fifo_uart_tx_uart_bit_timer.sv
// Bit-time counter: counts 0..clks_per_bit-1 while enabled and wraps,
// flagging the last cycle of every bit. Shared with the future receiver.
module uart_bit_timer #(
    parameter int clks_per_bit = 4,
    parameter int cnt_width    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [cnt_width-1:0] last_cnt = cnt_width'(clks_per_bit - 1);

    logic [cnt_width-1:0] cnt_r;

    assign tick = enable & (cnt_r == last_cnt);

    // Advance the bit-time counter, wrapping at the end of each bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (enable) begin
            if (cnt_r == last_cnt) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + cnt_width'(1);
            end
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO and sends each byte as an 8N1 UART frame.
// FETCH pulses the FIFO read, LATCH captures the registered read data,
// then START/DATA/STOP shift the frame out LSB first.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int data_width = 8,
    parameter int clock_freq = 125_000_000,
    parameter int baud_rate  = 115_200
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tx_en,
    fifo_uart_tx_if.master         fifo,
    output logic                   serial_out,
    output logic                   busy
);

    localparam int clks_per_bit = calc_clks_per_bit(clock_freq, baud_rate);
    localparam int cnt_width    = log2_ceil(clks_per_bit) + 1;
    localparam int idx_width    = (log2_ceil(data_width) < 1) ? 1 : log2_ceil(data_width);
    localparam logic [idx_width-1:0] last_idx = idx_width'(data_width - 1);

    if (clks_per_bit < 2) begin : g_bad_clks_per_bit
        $fatal(1, "fifo_uart_tx: clks_per_bit must be at least 2");
    end

    logic [2:0]            state_r;
    logic [data_width-1:0] shift_r;
    logic [idx_width-1:0]  bit_idx_r;
    logic                  rd_en_r;
    logic                  serial_r;
    logic                  busy_r;
    logic                  timer_en_s;
    logic                  timer_clear_s;
    logic                  tick_s;

    assign fifo.fifo_rd_en = rd_en_r;
    assign serial_out      = serial_r;
    assign busy            = busy_r;
    assign timer_clear_s   = ~timer_en_s;

    // Run the bit timer only while a frame is on the line.
    always_comb begin
        timer_en_s = 1'b0;
        case (state_r)
            ST_START, ST_DATA, ST_STOP: timer_en_s = 1'b1;
            default:                    timer_en_s = 1'b0;
        endcase
    end

    uart_bit_timer #(
        .clks_per_bit (clks_per_bit),
        .cnt_width    (cnt_width)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear_s),
        .enable (timer_en_s),
        .tick   (tick_s)
    );

    // Frame sequencer with registered read strobe, line and busy outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            shift_r   <= '0;
            bit_idx_r <= '0;
            rd_en_r   <= 1'b0;
            serial_r  <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (tx_en && !fifo.fifo_empty) begin
                        state_r <= ST_FETCH;
                        rd_en_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        rd_en_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    state_r <= ST_LATCH;
                    rd_en_r <= 1'b0;
                end
                ST_LATCH: begin
                    // FIFO data is valid now, one cycle after the strobe.
                    shift_r   <= fifo.fifo_dout;
                    bit_idx_r <= '0;
                    serial_r  <= 1'b0;
                    state_r   <= ST_START;
                end
                ST_START: begin
                    if (tick_s) begin
                        serial_r <= shift_r[0];
                        shift_r  <= shift_r >> 1;
                        state_r  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        if (bit_idx_r == last_idx) begin
                            serial_r <= 1'b1;
                            state_r  <= ST_STOP;
                        end else begin
                            serial_r  <= shift_r[0];
                            shift_r   <= shift_r >> 1;
                            bit_idx_r <= bit_idx_r + idx_width'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (tick_s) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    rd_en_r  <= 1'b0;
                    serial_r <= 1'b1;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a fast-baud instance fed by a queue-based FIFO
// model and checked by an independent serial decoder, plus a default-rate
// instance for bit/frame timing.
module tb_fifo_uart_tx;

    localparam int DW     = 8;
    localparam int CPB    = 4;
    localparam int CPB_B  = 125_000_000 / 115_200;
    localparam int FRAME  = (DW + 2) * CPB;

    logic clk = 1'b0;
    logic rst;
    logic tx_en_a = 1'b0;
    logic tx_en_b = 1'b0;
    logic serial_a, busy_a, serial_b, busy_b;

    fifo_uart_tx_if #(.data_width(8)) fif_a ();
    fifo_uart_tx_if #(.data_width(8)) fif_b ();

    fifo_uart_tx #(.data_width(8), .clock_freq(16), .baud_rate(4)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .tx_en      (tx_en_a),
        .fifo       (fif_a),
        .serial_out (serial_a),
        .busy       (busy_a)
    );

    fifo_uart_tx dut_b (
        .clk        (clk),
        .rst        (rst),
        .tx_en      (tx_en_b),
        .fifo       (fif_b),
        .serial_out (serial_b),
        .busy       (busy_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_cnt_a = 0;
    int drop_cnt = 0;
    int underflow_cnt = 0;
    int ferr_cnt = 0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] mem_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         start_q[$];

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input bit expect_out);
        wr_data = d;
        wr_en   = 1'b1;
        if (expect_out) exp_q.push_back(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int g;
        g = 0;
        while (rx_q.size() < n && g < budget) begin
            @(negedge clk);
            g++;
        end
        chk("rx_timeout", (rx_q.size() >= n) ? 1 : 0, 1);
    endtask

    task automatic wait_fall_a(input string tag, input int budget);
        int g;
        g = 0;
        while (serial_a !== 1'b0 && g < budget) begin
            @(negedge clk);
            g++;
        end
        chk(tag, serial_a, 0);
    endtask

    task automatic compare_rx(input string tag);
        int n;
        chk({tag, "_count"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    // Cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Depth-32 FIFO model with registered read data
    initial begin
        fif_a.fifo_empty = 1'b1;
        fif_a.fifo_dout  = 8'h00;
        forever begin
            @(posedge clk);
            if (fif_a.fifo_rd_en === 1'b1) begin
                if (mem_q.size() > 0) fif_a.fifo_dout <= mem_q.pop_front();
                else underflow_cnt++;
            end
            if (wr_en) begin
                if (mem_q.size() < 32) mem_q.push_back(wr_data);
                else drop_cnt++;
            end
            fif_a.fifo_empty <= (mem_q.size() == 0);
        end
    end

    // Serial decoder: samples mid-bit, recovers bytes, checks framing
    initial begin
        int         dcnt;
        int         k;
        logic       act;
        logic       prev;
        logic [7:0] b;
        act = 1'b0; prev = 1'b1; dcnt = 0; b = 8'h00;
        forever begin
            @(negedge clk);
            if (fif_a.fifo_rd_en === 1'b1) rd_cnt_a++;
            if (rst !== 1'b1) begin
                act  = 1'b0;
                prev = 1'b1;
            end else begin
                if (!act) begin
                    if (prev === 1'b1 && serial_a === 1'b0) begin
                        act = 1'b1; dcnt = 0; b = 8'h00;
                        start_q.push_back(cyc);
                    end
                end else begin
                    dcnt++;
                end
                if (act && (dcnt % CPB) == CPB / 2) begin
                    k = dcnt / CPB;
                    if (k == 0 && serial_a !== 1'b0) ferr_cnt++;
                    if (k >= 1 && k <= 8) b[k-1] = serial_a;
                    if (k == 9) begin
                        if (serial_a !== 1'b1) ferr_cnt++;
                        rx_q.push_back(b);
                        act = 1'b0;
                    end
                end
                prev = serial_a;
            end
        end
    end

    // Watchdog
    initial begin
        #900_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Directed sequence with random data
    initial begin
        int         g, mm, rd0, fr, npulse, nbusy, fbusy, t_edge, t_fall;
        logic       lvl;
        logic [9:0] fb;
        logic [7:0] rb, rb2;
        logic       ls[60];
        logic       lr[60];
        logic       lb[60];

        fif_b.fifo_empty = 1'b1;
        fif_b.fifo_dout  = 8'h00;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_serial_a", serial_a, 1);
        chk("reset_busy_a", busy_a, 0);
        chk("reset_rd_en_a", fif_a.fifo_rd_en, 0);
        chk("reset_serial_b", serial_b, 1);
        rst = 1'b1;
        @(negedge clk);

        // Default-rate timing: 0x55 toggles the line on every bit
        tx_en_b = 1'b1;
        fif_b.fifo_dout  = 8'h55;
        fif_b.fifo_empty = 1'b0;
        g = 0;
        while (fif_b.fifo_rd_en !== 1'b1 && g < 10) begin @(negedge clk); g++; end
        chk("dflt_fetch", fif_b.fifo_rd_en, 1);
        fif_b.fifo_empty = 1'b1;
        g = 0;
        while (serial_b !== 1'b0 && g < 10) begin @(negedge clk); g++; end
        chk("dflt_start", serial_b, 0);
        t_fall = cyc; t_edge = cyc; lvl = 1'b0;
        for (int seg = 1; seg <= 9; seg++) begin
            g = 0;
            while (serial_b === lvl && g < 1200) begin @(negedge clk); g++; end
            chk($sformatf("dflt_bit%0d_period", seg), cyc - t_edge, CPB_B);
            t_edge = cyc; lvl = serial_b;
        end
        g = 0;
        while (busy_b !== 1'b0 && g < 1200) begin @(negedge clk); g++; end
        chk("dflt_frame_len", cyc - t_fall, 10 * CPB_B);
        chk("dflt_idle_high", serial_b, 1);
        tx_en_b = 1'b0;

        // Single byte 0xA5, cycle-accurate trace
        tx_en_a = 1'b1;
        start_q.delete();
        wr_data = 8'hA5; wr_en = 1'b1; exp_q.push_back(8'hA5);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 0) wr_en = 1'b0;
            ls[i] = serial_a; lr[i] = fif_a.fifo_rd_en; lb[i] = busy_a;
        end
        fr = -1; npulse = 0; nbusy = 0; fbusy = -1;
        for (int i = 0; i < 60; i++) begin
            if (lr[i] === 1'b1) begin npulse++; if (fr < 0) fr = i; end
            if (lb[i] === 1'b1) begin nbusy++; if (fbusy < 0) fbusy = i; end
        end
        chk("single_rd_index", fr, 1);
        chk("single_rd_pulses", npulse, 1);
        chk("single_busy_first", fbusy, 1);
        chk("single_busy_cycles", nbusy, FRAME + 2);
        fb = {1'b1, 8'hA5, 1'b0};
        for (int bi = 0; bi < 10; bi++) begin
            mm = 0;
            for (int c = 0; c < CPB; c++) if (ls[3 + bi * CPB + c] !== fb[bi]) mm++;
            chk($sformatf("single_bit%0d", bi), mm, 0);
        end
        mm = 0;
        for (int i = 0; i < 3; i++) if (ls[i] !== 1'b1) mm++;
        for (int i = 3 + FRAME; i < 60; i++) if (ls[i] !== 1'b1) mm++;
        chk("single_idle_high", mm, 0);
        wait_rx(1, 20);
        compare_rx("single_data");

        // Back-to-back: three preloaded bytes
        tx_en_a = 1'b0;
        push(8'h00, 1'b1); push(8'hFF, 1'b1); push(8'h3C, 1'b1);
        repeat (2) @(negedge clk);
        start_q.delete();
        rd0 = rd_cnt_a;
        tx_en_a = 1'b1;
        wait_rx(3, 300);
        repeat (10) @(negedge clk);
        chk("b2b_rd_pulses", rd_cnt_a - rd0, 3);
        chk("b2b_starts", start_q.size(), 3);
        if (start_q.size() >= 3) begin
            chk("b2b_gap1", start_q[1] - start_q[0], FRAME + 3);
            chk("b2b_gap2", start_q[2] - start_q[1], FRAME + 3);
        end
        chk("b2b_fifo_empty", fif_a.fifo_empty, 1);
        compare_rx("b2b_data");

        // tx_en gating
        tx_en_a = 1'b0;
        rb  = 8'($urandom_range(0, 255));
        rb2 = 8'($urandom_range(0, 255));
        rd0 = rd_cnt_a;
        push(rb, 1'b1);
        repeat (200) @(negedge clk);
        chk("gate_no_fetch", rd_cnt_a - rd0, 0);
        chk("gate_line_idle", serial_a, 1);
        tx_en_a = 1'b1;
        wait_fall_a("gate_start", 20);
        repeat (3 * CPB) @(negedge clk);
        tx_en_a = 1'b0;
        push(rb2, 1'b0);
        repeat (150) @(negedge clk);
        chk("gate_one_fetch", rd_cnt_a - rd0, 1);
        chk("gate_busy_low", busy_a, 0);
        chk("gate_fifo_left", mem_q.size(), 1);
        compare_rx("gate_data");
        exp_q.push_back(rb2);
        tx_en_a = 1'b1;
        wait_rx(1, 100);
        compare_rx("gate_resume");

        // Reset mid-frame: popped byte is lost, line high at once
        push(8'($urandom_range(0, 255)), 1'b0);
        wait_fall_a("rst_frame_start", 20);
        repeat (3 * CPB) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_serial", serial_a, 1);
        chk("rst_async_rd_en", fif_a.fifo_rd_en, 0);
        chk("rst_async_busy", busy_a, 0);
        @(negedge clk);
        rst = 1'b1;
        rd0 = rd_cnt_a;
        mm = 0;
        repeat (100) begin
            @(negedge clk);
            if (serial_a !== 1'b1) mm++;
        end
        chk("rst_line_high", mm, 0);
        chk("rst_no_fetch", rd_cnt_a - rd0, 0);
        chk("rst_fifo_empty", mem_q.size(), 0);
        chk("rst_no_byte", rx_q.size(), 0);

        // 32 random bytes written at full rate
        for (int i = 0; i < 32; i++) begin
            g = 0;
            while (mem_q.size() >= 32 && g < 2000) begin @(negedge clk); g++; end
            push(8'($urandom_range(0, 255)), 1'b1);
        end
        wait_rx(32, 32 * (FRAME + 8) + 100);
        compare_rx("rand_data");
        chk("rand_no_drop", drop_cnt, 0);
        chk("no_underflow", underflow_cnt, 0);
        chk("no_framing_error", ferr_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Serial transmit stage that sits directly downstream of the byte FIFO. It drains bytes whenever the FIFO is non-empty and transmission is enabled. Each byte goes out as an 8N1 UART frame on a single line, to the host link or the debug port. It drives the FIFO's read side and must match the FIFO's registered read timing: read data is valid the cycle after the read-enable cycle.

Parameters:
data_width, 8, width of a FIFO word and of the UART data field (LSB first)
clock_freq, 125_000_000, clk frequency in Hz
baud_rate, 115_200, serial bit rate in bits/s
clks_per_bit, clock_freq/baud_rate (integer division), cycles per serial bit; must be >= 2
cnt_width, `log2(clks_per_bit)+1, width of the bit-time counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
tx_en  input  1  permit start of new frames; sampled only in IDLE
fifo_empty  input  1  FIFO empty flag
fifo_dout  input  data_width  FIFO read data, valid the cycle after fifo_rd_en
fifo_rd_en  output  1  FIFO read strobe, registered, one-cycle pulse per byte
serial_out  output  1  UART line, idle high
busy  output  1  high from FETCH through last cycle of stop bit

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, fifo_rd_en=0, serial_out=1, busy=0, shift register=0, bit counter=0, bit index=0. These take effect immediately, not at the next clk edge.
- Reset mid-frame: the frame is abandoned and the line returns high at once. The byte already popped is lost; no re-read is attempted.
- States: IDLE, FETCH, LATCH, START, DATA, STOP.
- IDLE: serial_out=1, busy=0. If tx_en=1 and fifo_empty=0 at a clk edge, go to FETCH.
- FETCH: lasts exactly 1 cycle, fifo_rd_en=1, busy=1. Go to LATCH.
- LATCH: lasts 1 cycle, fifo_rd_en=0. Capture fifo_dout into the shift register at the end of the cycle. Go to START.
- START: serial_out=0 for clks_per_bit cycles.
- DATA: data_width bits, LSB first, each held clks_per_bit cycles.
- STOP: serial_out=1 for clks_per_bit cycles, then go to IDLE.
- Latency: with the IDLE sample edge at cycle 0, fifo_rd_en is high in cycle 1 and serial_out falls in cycle 3. Frame length is (data_width+2)*clks_per_bit cycles.
- Back-to-back bytes: STOP→IDLE→FETCH→LATCH gives a minimum of 3 extra idle-high cycles between frames, on top of the stop bit.
- fifo_rd_en is never asserted when fifo_empty=0 was not observed in the preceding IDLE cycle. At most one read is in flight; this block is the FIFO's only reader.
- tx_en=0 during FETCH..STOP does not abort the frame; it only blocks the next IDLE→FETCH.
- fifo_empty toggling outside IDLE is ignored.
- Bit counter counts 0..clks_per_bit-1 and wraps; the bit index advances on wrap. No off-by-one: every bit holds exactly clks_per_bit cycles.
- Elaboration check: clks_per_bit < 2 is a fatal error.

Decomposition:
- Shared package/header alongside util.vh holds:
  - state encodings (3-bit localparams)
  - UART_FRAME_BITS = data_width+2
  - the clks_per_bit derivation
- `log2 comes from util.vh.
- One natural sub-module: uart_bit_timer, the clks_per_bit counter.
  - Inputs: clear and enable.
  - Output: a one-cycle tick on the last cycle of each bit.
  - Instantiated once; reused by the future receive stage.

Test Plan:
- Reset: hold rst=0 mid-frame → serial_out=1, fifo_rd_en=0, busy=0 within the same cycle; after release with fifo_empty=1, the line stays high for 100 cycles.
- Single byte: clock_freq=16, baud_rate=4 (clks_per_bit=4), FIFO holds 0xA5 → fifo_rd_en one-cycle pulse 1 cycle after the empty flag drops; line shows 0,1,0,1,0,0,1,0,1,1, each 4 cycles (40 total); busy high 42 cycles.
- Back-to-back: FIFO preloaded with 0x00, 0xFF, 0x3C → three frames; each idle-high gap = stop bit + 3 cycles; exactly 3 fifo_rd_en pulses; FIFO empty after the third.
- tx_en gating: tx_en=0 with FIFO non-empty → no fifo_rd_en for 200 cycles. Set tx_en=1, then drop it mid-DATA → the current frame completes intact and no further fetch occurs.
- FIFO integration: instantiate with fifo (depth 32); push 32 random bytes at full rate → serial decoder recovers all 32 in order; FIFO full never causes a dropped byte at the bench's writer.
- Default timing: defaults (clks_per_bit=1085) → measured bit period = 1085 cycles ±0, frame = 10850 cycles.
